// File: rtl/core_pkg.sv
// Shared definitions for the delayed-branch core: ALU codes, opcodes,
// branch kinds, instruction field positions and decode result types.
package core_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_PASS = 4'd4;

    localparam logic [3:0] OPC_NOP  = 4'd0;
    localparam logic [3:0] OPC_ADD  = 4'd1;
    localparam logic [3:0] OPC_SUB  = 4'd2;
    localparam logic [3:0] OPC_AND  = 4'd3;
    localparam logic [3:0] OPC_OR   = 4'd4;
    localparam logic [3:0] OPC_ADDI = 4'd5;
    localparam logic [3:0] OPC_LI   = 4'd6;
    localparam logic [3:0] OPC_BEQ  = 4'd7;
    localparam logic [3:0] OPC_BNE  = 4'd8;
    localparam logic [3:0] OPC_J    = 4'd9;

    localparam logic [1:0] BR_NONE = 2'd0;
    localparam logic [1:0] BR_BEQ  = 2'd1;
    localparam logic [1:0] BR_BNE  = 2'd2;
    localparam logic [1:0] BR_J    = 2'd3;

    localparam int OPC_LO = 28;
    localparam int RD_LO  = 24;
    localparam int RS1_LO = 20;
    localparam int RS2_LO = 16;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {SEL_RS2 = 2'd0, SEL_SIMM = 2'd1, SEL_ZERO = 2'd2} sel_b_e;
    typedef enum logic {S_RUN = 1'b0, S_SLOT = 1'b1} issue_state_e;

    typedef struct packed {
        logic [3:0] alu_op;
        sel_b_e     sel_b;
        logic       wen;
        logic [1:0] br_kind;
        logic       illegal;
    } decode_t;

    function automatic logic is_branch(input logic [3:0] opc);
        return (opc == OPC_BEQ) || (opc == OPC_BNE) || (opc == OPC_J);
    endfunction

endpackage

// File: rtl/id_issue_stage_if.sv
// Issue bus from the decode/issue stage to EX: registered operands,
// writeback and branch control under a valid/ready handshake.
interface id_issue_stage_if #(
    parameter int XLEN       = 32,
    parameter int NREGS_LOG2 = 4
);
    logic                  valid;
    logic                  ready;
    logic [XLEN-1:0]       op_a;
    logic [XLEN-1:0]       op_b;
    logic [3:0]            alu_op;
    logic [NREGS_LOG2-1:0] rd;
    logic                  wen;
    logic [1:0]            br_kind;
    logic [XLEN-1:0]       br_target;
    logic                  in_slot;
    logic                  slot_err;

    modport master (
        output valid, op_a, op_b, alu_op, rd, wen, br_kind, br_target, in_slot, slot_err,
        input  ready
    );

    modport slave (
        input  valid, op_a, op_b, alu_op, rd, wen, br_kind, br_target, in_slot, slot_err,
        output ready
    );
endinterface

// File: rtl/id_issue_stage_decode.sv
// Combinational opcode decode: ALU operation, operand-B source,
// writeback enable, branch kind and illegal flag.
module id_decode
    import core_pkg::*;
#(
    parameter int NREGS_LOG2 = 4
) (
    input  logic [3:0]            i_opc,
    input  logic [NREGS_LOG2-1:0] i_rd,
    output decode_t               o_dec
);

    // Opcode table; illegal opcodes fall back to a NOP shape.
    always_comb begin
        o_dec = '{alu_op: ALU_ADD, sel_b: SEL_RS2, wen: 1'b0, br_kind: BR_NONE, illegal: 1'b0};
        case (i_opc)
            OPC_NOP:  o_dec.wen = 1'b0;
            OPC_ADD:  o_dec.wen = 1'b1;
            OPC_SUB:  begin o_dec.alu_op = ALU_SUB; o_dec.wen = 1'b1; end
            OPC_AND:  begin o_dec.alu_op = ALU_AND; o_dec.wen = 1'b1; end
            OPC_OR:   begin o_dec.alu_op = ALU_OR;  o_dec.wen = 1'b1; end
            OPC_ADDI: begin o_dec.sel_b = SEL_SIMM; o_dec.wen = 1'b1; end
            OPC_LI:   begin o_dec.alu_op = ALU_PASS; o_dec.sel_b = SEL_SIMM; o_dec.wen = 1'b1; end
            OPC_BEQ:  begin o_dec.alu_op = ALU_SUB; o_dec.br_kind = BR_BEQ; end
            OPC_BNE:  begin o_dec.alu_op = ALU_SUB; o_dec.br_kind = BR_BNE; end
            OPC_J:    begin o_dec.alu_op = ALU_PASS; o_dec.sel_b = SEL_ZERO; o_dec.br_kind = BR_J; end
            default:  o_dec.illegal = 1'b1;
        endcase
        if (i_rd == {NREGS_LOG2{1'b0}}) begin
            o_dec.wen = 1'b0;
        end else begin
            o_dec.wen = o_dec.wen;
        end
    end

endmodule

// File: rtl/id_issue_stage.sv
// Decode/issue stage: reads the register file, registers ALU operands and
// control for EX, and tracks the single architectural delay slot.
module id_issue_stage
    import core_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREGS_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_if_valid,
    output logic                  o_if_ready,
    input  logic [31:0]           i_if_instr,
    input  logic [XLEN-1:0]       i_if_pc,
    output logic [NREGS_LOG2-1:0] o_rf_raddr1,
    output logic [NREGS_LOG2-1:0] o_rf_raddr2,
    input  logic [XLEN-1:0]       i_rf_rdata1,
    input  logic [XLEN-1:0]       i_rf_rdata2,
    id_issue_stage_if.master      ex
);

    issue_state_e          r_state;
    logic                  r_valid;
    logic [XLEN-1:0]       r_op_a;
    logic [XLEN-1:0]       r_op_b;
    logic [3:0]            r_alu_op;
    logic [NREGS_LOG2-1:0] r_rd;
    logic                  r_wen;
    logic [1:0]            r_br_kind;
    logic [XLEN-1:0]       r_br_target;
    logic                  r_in_slot;
    logic                  r_slot_err;

    decode_t               w_dec;
    logic [3:0]            w_opc;
    logic [NREGS_LOG2-1:0] w_rd;
    logic [15:0]           w_imm;
    logic [XLEN-1:0]       w_simm;
    logic [XLEN-1:0]       w_op_b;
    logic [XLEN-1:0]       w_target;
    logic                  w_accept;
    logic                  w_branch;
    logic                  w_squash;
    logic                  w_kill;

    assign w_opc       = i_if_instr[OPC_LO +: 4];
    assign w_rd        = i_if_instr[RD_LO +: NREGS_LOG2];
    assign w_imm       = i_if_instr[IMM_LO +: 16];
    assign w_simm      = {{(XLEN-16){w_imm[15]}}, w_imm};
    assign o_rf_raddr1 = i_if_instr[RS1_LO +: NREGS_LOG2];
    assign o_rf_raddr2 = i_if_instr[RS2_LO +: NREGS_LOG2];

    id_decode #(.NREGS_LOG2(NREGS_LOG2)) u_decode (
        .i_opc (w_opc),
        .i_rd  (w_rd),
        .o_dec (w_dec)
    );

    assign o_if_ready = !r_valid || ex.ready;
    assign w_accept   = i_if_valid && o_if_ready;
    assign w_branch   = is_branch(w_opc);
    // A branch sitting in the delay slot is demoted to a NOP and flagged.
    assign w_squash   = (r_state == S_SLOT) && w_branch;
    assign w_kill     = w_squash || w_dec.illegal;
    assign w_target   = i_if_pc + {{(XLEN-3){1'b0}}, 3'd4} + (w_simm << 2);

    // Operand-B source select.
    always_comb begin
        w_op_b = i_rf_rdata2;
        case (w_dec.sel_b)
            SEL_RS2:  w_op_b = i_rf_rdata2;
            SEL_SIMM: w_op_b = w_simm;
            SEL_ZERO: w_op_b = {XLEN{1'b0}};
            default:  w_op_b = i_rf_rdata2;
        endcase
    end

    // Issue register and delay-slot FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_valid     <= 1'b0;
            r_op_a      <= {XLEN{1'b0}};
            r_op_b      <= {XLEN{1'b0}};
            r_alu_op    <= ALU_ADD;
            r_rd        <= {NREGS_LOG2{1'b0}};
            r_wen       <= 1'b0;
            r_br_kind   <= BR_NONE;
            r_br_target <= {XLEN{1'b0}};
            r_in_slot   <= 1'b0;
            r_slot_err  <= 1'b0;
        end else if (w_accept) begin
            r_valid     <= 1'b1;
            r_op_a      <= i_rf_rdata1;
            r_op_b      <= w_op_b;
            r_alu_op    <= w_kill ? ALU_ADD : w_dec.alu_op;
            r_rd        <= w_rd;
            r_wen       <= w_kill ? 1'b0 : w_dec.wen;
            r_br_kind   <= w_kill ? BR_NONE : w_dec.br_kind;
            r_br_target <= (w_kill || (w_dec.br_kind == BR_NONE)) ? {XLEN{1'b0}} : w_target;
            r_in_slot   <= (r_state == S_SLOT);
            r_slot_err  <= w_squash;
            case (r_state)
                S_RUN:   r_state <= w_branch ? S_SLOT : S_RUN;
                S_SLOT:  r_state <= S_RUN;
                default: r_state <= S_RUN;
            endcase
        end else begin
            r_slot_err <= 1'b0;
            r_valid    <= ex.ready ? 1'b0 : r_valid;
        end
    end

    assign ex.valid     = r_valid;
    assign ex.op_a      = r_op_a;
    assign ex.op_b      = r_op_b;
    assign ex.alu_op    = r_alu_op;
    assign ex.rd        = r_rd;
    assign ex.wen       = r_wen;
    assign ex.br_kind   = r_br_kind;
    assign ex.br_target = r_br_target;
    assign ex.in_slot   = r_in_slot;
    assign ex.slot_err  = r_slot_err;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed and randomized bench for id_issue_stage against an
// instruction-level reference model of the issue stage.
module tb_id_issue_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_instr = 32'd0;
    logic [31:0] if_pc = 32'd0;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [31:0] rf_rdata1 = 32'd0;
    logic [31:0] rf_rdata2 = 32'd0;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: what EX should currently see.
    logic [31:0] m_a, m_b, m_tgt;
    logic [3:0]  m_op, m_rd;
    logic [1:0]  m_bk;
    logic        m_valid, m_wen, m_slot, m_err, m_a_known, m_b_known;
    logic        m_pending;

    id_issue_stage_if #(.XLEN(32), .NREGS_LOG2(4)) ex_if ();

    id_issue_stage #(.XLEN(32), .NREGS_LOG2(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_if_valid  (if_valid),
        .o_if_ready  (if_ready),
        .i_if_instr  (if_instr),
        .i_if_pc     (if_pc),
        .o_rf_raddr1 (rf_raddr1),
        .o_rf_raddr2 (rf_raddr2),
        .i_rf_rdata1 (rf_rdata1),
        .i_rf_rdata2 (rf_rdata2),
        .ex          (ex_if.master)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk(input int opc, input int rd, input int rs1, input int rs2, input int imm);
        logic [31:0] w;
        w = {opc[3:0], rd[3:0], rs1[3:0], rs2[3:0], imm[15:0]};
        return w;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_a = 32'd0; m_b = 32'd0; m_op = 4'd0; m_rd = 4'd0;
        m_wen = 1'b0; m_bk = 2'd0; m_tgt = 32'd0; m_slot = 1'b0; m_err = 1'b0;
        m_a_known = 1'b1; m_b_known = 1'b1; m_pending = 1'b0;
    endtask

    task automatic check_outputs();
        check("ex_valid", {31'd0, ex_if.valid}, {31'd0, m_valid});
        check("alu_op", {28'd0, ex_if.alu_op}, {28'd0, m_op});
        check("rd", {28'd0, ex_if.rd}, {28'd0, m_rd});
        check("wen", {31'd0, ex_if.wen}, {31'd0, m_wen});
        check("br_kind", {30'd0, ex_if.br_kind}, {30'd0, m_bk});
        check("br_target", ex_if.br_target, m_tgt);
        check("in_slot", {31'd0, ex_if.in_slot}, {31'd0, m_slot});
        check("slot_err", {31'd0, ex_if.slot_err}, {31'd0, m_err});
        if (m_a_known) check("op_a", ex_if.op_a, m_a);
        if (m_b_known) check("op_b", ex_if.op_b, m_b);
    endtask

    // Predict the issued instruction purely from the ISA rules.
    task automatic model_issue(input logic [31:0] ins, input logic [31:0] pc,
                               input logic [31:0] d1, input logic [31:0] d2);
        int          opc;
        logic [31:0] simm;
        logic        is_br;
        opc   = int'(ins >> 28);
        simm  = {{16{ins[15]}}, ins[15:0]};
        is_br = (opc == 7) || (opc == 8) || (opc == 9);
        m_valid = 1'b1; m_rd = ins[27:24]; m_a = d1; m_b = d2;
        m_a_known = 1'b0; m_b_known = 1'b0; m_op = 4'd0; m_wen = 1'b0; m_bk = 2'd0;
        if (opc >= 1 && opc <= 4) begin
            m_op = 4'(opc - 1); m_wen = 1'b1; m_a_known = 1'b1; m_b_known = 1'b1;
        end else if (opc == 5) begin
            m_wen = 1'b1; m_b = simm; m_a_known = 1'b1; m_b_known = 1'b1;
        end else if (opc == 6) begin
            m_op = 4'd4; m_wen = 1'b1; m_b = simm; m_b_known = 1'b1;
        end else if (opc == 7 || opc == 8) begin
            m_op = 4'd1; m_bk = 2'(opc - 6); m_a_known = 1'b1; m_b_known = 1'b1;
        end else if (opc == 9) begin
            m_op = 4'd4; m_bk = 2'd3; m_b = 32'd0; m_b_known = 1'b1;
        end
        if (m_rd == 4'd0) m_wen = 1'b0;
        m_slot = m_pending;
        m_err  = m_pending && is_br;
        if (m_err) begin
            m_op = 4'd0; m_wen = 1'b0; m_bk = 2'd0; m_a_known = 1'b0; m_b_known = 1'b0;
        end
        m_tgt = (m_bk == 2'd0) ? 32'd0 : pc + 32'd4 + (simm << 2);
        m_pending = m_pending ? 1'b0 : is_br;
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] d1, input logic [31:0] d2, input logic rdy);
        logic exp_ready;
        @(negedge clk);
        if_valid = v; if_instr = ins; if_pc = pc;
        rf_rdata1 = d1; rf_rdata2 = d2; ex_if.ready = rdy;
        #1;
        exp_ready = !m_valid || rdy;
        check("if_ready", {31'd0, if_ready}, {31'd0, exp_ready});
        check("rf_raddr1", {28'd0, rf_raddr1}, {28'd0, ins[23:20]});
        check("rf_raddr2", {28'd0, rf_raddr2}, {28'd0, ins[19:16]});
        if (v && exp_ready) begin
            model_issue(ins, pc, d1, d2);
        end else begin
            m_err = 1'b0;
            if (rdy) m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; if_valid = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        ex_if.ready = 1'b1;
        model_reset();
        do_reset();

        step(1'b1, mk(1, 3, 1, 2, 0), 32'h0, 32'd5, 32'd7, 1'b1);
        check("add_op_a_const", ex_if.op_a, 32'd5);
        step(1'b1, mk(5, 2, 0, 0, 16'hFFFF), 32'h4, 32'd1, 32'd2, 1'b1);
        check("addi_simm_const", ex_if.op_b, 32'hFFFF_FFFF);
        step(1'b1, mk(6, 0, 0, 0, 9), 32'h8, 32'd0, 32'd0, 1'b1);
        step(1'b1, mk(8, 0, 1, 2, 16'hFFFE), 32'h100, 32'd3, 32'd4, 1'b1);
        check("bne_target_const", ex_if.br_target, 32'h0000_00FC);
        step(1'b1, mk(1, 4, 1, 2, 0), 32'h104, 32'd8, 32'd9, 1'b1);
        step(1'b1, mk(2, 5, 1, 2, 0), 32'h108, 32'd20, 32'd9, 1'b1);
        step(1'b1, mk(7, 0, 1, 2, 3), 32'h200, 32'd1, 32'd1, 1'b1);
        step(1'b1, mk(9, 0, 0, 0, 16'h0010), 32'h204, 32'd0, 32'd0, 1'b1);
        step(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b1);
        step(1'b1, mk(3, 6, 1, 2, 0), 32'h300, 32'hF0F0, 32'h0FF0, 1'b1);

        for (int i = 0; i < 3; i++) step(1'b1, mk(4, 7, 1, 2, 0), 32'h304, 32'h1, 32'h2, 1'b0);
        step(1'b1, mk(4, 7, 1, 2, 0), 32'h304, 32'h1, 32'h2, 1'b1);

        step(1'b1, mk(9, 0, 0, 0, 16'h8000), 32'h400, 32'd0, 32'd0, 1'b0);
        do_reset();
        step(1'b1, mk(1, 1, 2, 3, 0), 32'h500, 32'd11, 32'd22, 1'b1);
        step(1'b1, mk(12, 5, 1, 2, 0), 32'h504, 32'd1, 32'd2, 1'b1);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            int          opc;
            opc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(7, 9)) : int'($urandom_range(0, 15));
            ins = {opc[3:0], 28'($urandom)};
            step(1'($urandom_range(0, 3) != 0), ins, $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 3) != 0));
            if (i == 200) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
